// File: rtl/ad_row_packer.sv
// Input adapter for the BCEDN pipeline.
// Reads words from the input FIFO, packs PACK_NUM of them into one row per EC-1 handshake, and counts ROWS rows per frame.
module ad_row_packer #(
    parameter int DATA_IN_WIDTH  = 8,
    parameter int PACK_NUM       = 4,
    parameter int ROWS           = 32,
    parameter int DATA_OUT_WIDTH = DATA_IN_WIDTH * PACK_NUM
) (
    input  logic                      clkw,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DATA_IN_WIDTH-1:0]  fifo_dout,
    input  logic                      fifo_empty,
    output logic                      fifo_rd,
    input  logic                      ec_rdy,
    output logic [DATA_OUT_WIDTH-1:0] data_out,
    output logic                      out_en,
    output logic                      busy,
    output logic                      done
);

    localparam int CNT_W = $clog2(PACK_NUM + 1);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_EMIT,
        S_DONE
    } state_t;

    state_t                    state_reg;
    state_t                    state_next;
    logic [CNT_W-1:0]          rd_cnt_reg;
    logic [CNT_W-1:0]          wr_cnt_reg;
    logic [ROW_W-1:0]          row_cnt_reg;
    logic [DATA_OUT_WIDTH-1:0] row_buf_reg;
    logic [DATA_OUT_WIDTH-1:0] data_out_reg;
    logic                      rd_pend_reg;
    logic                      out_en_reg;
    logic                      done_reg;
    logic                      rd_next;
    logic                      last_word;
    logic                      last_row;

    assign last_word = rd_pend_reg && (wr_cnt_reg == CNT_W'(PACK_NUM - 1));
    assign last_row  = (row_cnt_reg == ROW_W'(ROWS - 1));

    always_comb begin
        state_next = state_reg;
        rd_next    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start)
                    state_next = S_FILL;
            end
            S_FILL: begin
                // Gated by rst so nothing is pulled from the FIFO while reset is held
                rd_next = rst && !fifo_empty && (rd_cnt_reg < CNT_W'(PACK_NUM));
                if (last_word)
                    state_next = S_EMIT;
            end
            S_EMIT: begin
                if (ec_rdy)
                    state_next = last_row ? S_DONE : S_FILL;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clkw) begin
        if (!rst) begin
            state_reg    <= S_IDLE;
            rd_cnt_reg   <= '0;
            wr_cnt_reg   <= '0;
            row_cnt_reg  <= '0;
            row_buf_reg  <= '0;
            data_out_reg <= '0;
            rd_pend_reg  <= 1'b0;
            out_en_reg   <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            rd_pend_reg <= rd_next;
            out_en_reg  <= 1'b0;
            done_reg    <= (state_reg == S_DONE);
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        rd_cnt_reg  <= '0;
                        wr_cnt_reg  <= '0;
                        row_cnt_reg <= '0;
                    end
                end
                S_FILL: begin
                    if (rd_next)
                        rd_cnt_reg <= rd_cnt_reg + CNT_W'(1);
                    // The FIFO presents data one cycle after the read strobe
                    if (rd_pend_reg) begin
                        row_buf_reg <= {row_buf_reg[DATA_OUT_WIDTH-DATA_IN_WIDTH-1:0], fifo_dout};
                        wr_cnt_reg  <= wr_cnt_reg + CNT_W'(1);
                    end
                end
                S_EMIT: begin
                    if (ec_rdy) begin
                        data_out_reg <= row_buf_reg;
                        out_en_reg   <= 1'b1;
                        rd_cnt_reg   <= '0;
                        wr_cnt_reg   <= '0;
                        if (!last_row)
                            row_cnt_reg <= row_cnt_reg + ROW_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign fifo_rd  = rd_next;
    assign data_out = data_out_reg;
    assign out_en   = out_en_reg;
    assign done     = done_reg;
    assign busy     = (state_reg != S_IDLE);

endmodule

// File: tb/tb_ad_row_packer.sv
// Bench for ad_row_packer: a queue-backed FIFO feeds random words, and each emitted row is compared with the expected grouping of those words.
module tb_ad_row_packer;

    localparam int DIW = 8;
    localparam int PK  = 4;
    localparam int NR  = 3;
    localparam int DOW = DIW * PK;

    logic           clkw;
    logic           rst;
    logic           start;
    logic [DIW-1:0] fifo_dout;
    logic           fifo_empty;
    logic           fifo_rd;
    logic           ec_rdy;
    logic [DOW-1:0] data_out;
    logic           out_en;
    logic           busy;
    logic           done;

    ad_row_packer #(
        .DATA_IN_WIDTH(DIW),
        .PACK_NUM     (PK),
        .ROWS         (NR)
    ) dut (
        .clkw      (clkw),
        .rst       (rst),
        .start     (start),
        .fifo_dout (fifo_dout),
        .fifo_empty(fifo_empty),
        .fifo_rd   (fifo_rd),
        .ec_rdy    (ec_rdy),
        .data_out  (data_out),
        .out_en    (out_en),
        .busy      (busy),
        .done      (done)
    );

    initial clkw = 1'b0;
    always #5 clkw = ~clkw;

    logic [DIW-1:0] fifo_q[$];
    logic           force_empty;
    logic           rd_seen;
    int             pops;
    int             cyc;
    int             n_checks;
    int             n_fail;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: FIFO reads are taken at the edge and the word appears just after it
    task automatic step();
        fifo_empty = (fifo_q.size() == 0) || force_empty;
        @(negedge clkw);
        rd_seen = fifo_rd;
        if (rd_seen)
            check("rd_on_empty", fifo_empty, 0);
        @(posedge clkw);
        #1;
        if (rd_seen && fifo_q.size() > 0) begin
            fifo_dout = fifo_q.pop_front();
            pops++;
        end
        cyc++;
    endtask

    task automatic run_frame(input bit fixed_first, input int stall_at, input int bp_row,
                             input int bp_len, input bit start_mid, input int exp_first);
        logic [DIW-1:0] fixed_w[4];
        logic [DOW-1:0] exp_rows[NR];
        logic [DIW-1:0] w;
        int  rows_seen;
        int  last_en;
        int  stall_cnt;
        int  bp_cnt;
        bit  stall_done;
        bit  bp_done;
        bit  finished;
        bit  exp_done;
        fixed_w = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        for (int r = 0; r < NR; r++) begin
            exp_rows[r] = '0;
            for (int k = 0; k < PK; k++) begin
                w = (fixed_first && r == 0) ? fixed_w[k] : DIW'($urandom);
                fifo_q.push_back(w);
                exp_rows[r] = (exp_rows[r] << DIW) | DOW'(w);
            end
        end
        rows_seen = 0; last_en = -10; stall_cnt = 0; bp_cnt = 0;
        stall_done = 0; bp_done = 0; finished = 0;
        pops = 0; cyc = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        while (!finished && cyc < 200) begin
            if (out_en) begin
                check("row_data", data_out, exp_rows[rows_seen % NR]);
                if (exp_first > 0)
                    check("row_latency", cyc, exp_first + (PK + 2) * rows_seen);
                rows_seen++;
                last_en = cyc;
            end
            exp_done = (rows_seen == NR) && (cyc == last_en + 1);
            check("done_pulse", done, exp_done);
            if (done) begin
                check("busy_after_done", busy, 0);
                finished = 1;
            end else begin
                check("busy_in_frame", busy, 1);
            end
            if (start_mid && cyc == 3)
                start = 1'b1;
            else
                start = 1'b0;
            if (stall_cnt > 0) begin
                stall_cnt--;
                if (stall_cnt == 0)
                    force_empty = 1'b0;
            end
            if (!stall_done && stall_at > 0 && pops == stall_at) begin
                force_empty = 1'b1;
                stall_cnt   = 3;
                stall_done  = 1;
            end
            if (bp_cnt > 0) begin
                check("bp_no_out_en", out_en, 0);
                check("bp_no_fifo_rd", rd_seen, 0);
                bp_cnt--;
                if (bp_cnt == 0)
                    ec_rdy = 1'b1;
            end
            if (!bp_done && bp_len > 0 && pops == PK * (bp_row + 1)) begin
                ec_rdy  = 1'b0;
                bp_cnt  = bp_len;
                bp_done = 1;
            end
            if (!finished)
                step();
        end
        check("frame_timeout", finished, 1);
        check("row_count", rows_seen, NR);
        check("fifo_drained", fifo_q.size(), 0);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b0;
        start       = 1'b0;
        ec_rdy      = 1'b1;
        fifo_dout   = '0;
        force_empty = 1'b0;
        fifo_empty  = 1'b1;
        for (int i = 0; i < 3; i++)
            step();
        check("reset_data_out", data_out, 0);
        check("reset_out_en", out_en, 0);
        check("reset_done", done, 0);
        check("reset_busy", busy, 0);
        check("reset_fifo_rd", fifo_rd, 0);
        rst = 1'b1;
        step();

        // Basic frame with the known first row and nominal timing
        run_frame(1, 0, 0, 0, 0, PK + 3);
        $display("frame basic: rows checked, total assertions %0d", n_checks);

        // Reset in the middle of filling, then a clean frame from fresh data
        for (int i = 0; i < 3 * PK; i++)
            fifo_q.push_back(DIW'($urandom));
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++)
            step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++)
            step();
        check("midreset_data_out", data_out, 0);
        check("midreset_out_en", out_en, 0);
        check("midreset_done", done, 0);
        check("midreset_busy", busy, 0);
        check("midreset_fifo_rd", fifo_rd, 0);
        fifo_q.delete();
        rst = 1'b1;
        step();
        run_frame(0, 0, 0, 0, 0, PK + 3);
        $display("frame after mid-fill reset: total assertions %0d", n_checks);

        // FIFO underflow for 3 cycles after the second word
        run_frame(0, 2, 0, 0, 0, PK + 3 + 3);
        $display("frame with underflow: total assertions %0d", n_checks);

        // Backpressure on the second row for 10 cycles
        run_frame(0, 0, 1, 10, 0, 0);
        $display("frame with backpressure: total assertions %0d", n_checks);

        // Stray start pulse while filling
        run_frame(0, 0, 0, 0, 1, PK + 3);
        $display("frame with stray start: total assertions %0d", n_checks);

        // Several back-to-back random frames
        for (int f = 0; f < 3; f++) begin
            run_frame(0, (f == 1) ? 5 : 0, f, (f == 2) ? 4 : 0, 0, 0);
            $display("random frame %0d: total assertions %0d", f, n_checks);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
